freq_gate_counter: RTL and testbench

Measurement stage of the frequency meter, directly downstream of the timebase mux. It takes the selected gate clock produced by the mux and counts rising edges of the external signal under test between consecutive gate rising edges. It latches each window's result as a BCD count with an overflow flag and a one-cycle valid strobe, for the display stage that follows. A change of the mux selector restarts the measurement, so windows never mix two timebases.

---
 rtl/freq_pkg.sv | 7 +
 rtl/bcd_digit.sv | 23 ++
 rtl/freq_gate_counter.sv | 106 ++++++++++
 tb/tb_freq_gate_counter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_pkg.sv
// freq_pkg: shared types and constants for the gated BCD frequency counter
package freq_pkg;
    typedef enum logic [1:0] {IDLE, COUNT, LATCH} state_t;
    typedef logic [3:0] bcd_t;
    localparam bcd_t BCD_MAX = 4'd9;
    localparam int DIGITS_DEF = 4;
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD decade; clr loads inc so a cleared window can start at 1
module bcd_digit
    import freq_pkg::*;
(
    input  logic clk100KHZ,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    input  logic hold,
    output bcd_t q,
    output logic carry
);
    bcd_t q_q, q_d;
    assign carry = inc & (q_q == BCD_MAX);
    assign q     = q_q;
    always_comb begin
        q_d = clr ? {3'b000, inc} : (hold | ~inc) ? q_q : carry ? '0 : q_q + 4'd1;
    end
    always_ff @(posedge clk100KHZ) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end
endmodule

// File: rtl/freq_gate_counter.sv
// freq_gate_counter: counts sinal rising edges per gate period and latches a BCD result
module freq_gate_counter
    import freq_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk100KHZ,
    input  logic                  rst,
    input  logic                  gate,
    input  logic                  sinal,
    input  logic [3:0]            seletor,
    output logic [4*DIGITS-1:0]   contagem,
    output logic                  overflow,
    output logic                  valido,
    output logic                  medindo
);
    state_t state_q, state_d;
    logic [2:0] sync_q;
    logic [1:0] gate_q;
    logic [3:0] sel_q;
    logic sat_q, sat_d, ovf_q, ovf_d, vld_q, vld_d;
    logic [4*DIGITS-1:0] cont_q, cont_d, cnt;
    logic [DIGITS-1:0] carry, inc_c;
    logic sig_edge, gate_edge, sel_chg, clr, inc, full;
    assign sig_edge  = sync_q[1] & ~sync_q[2];
    assign gate_edge = gate_q[0] & ~gate_q[1];
    assign sel_chg   = seletor != sel_q;
    // carry out of the top decade means the increment would pass all-nines
    assign full      = carry[DIGITS-1];
    genvar i;
    for (i = 0; i < DIGITS; i++) begin : g_dig
        if (i == 0) begin : g_lsd
            assign inc_c[i] = inc;
        end else begin : g_upper
            assign inc_c[i] = carry[i-1] & ~clr;
        end
        bcd_digit u_dig (
            .clk100KHZ(clk100KHZ),
            .rst      (rst),
            .clr      (clr),
            .inc      (inc_c[i]),
            .hold     (full),
            .q        (cnt[4*i +: 4]),
            .carry    (carry[i])
        );
    end
    always_comb begin
        state_d = state_q;
        clr     = 1'b1;
        inc     = 1'b0;
        sat_d   = sat_q;
        cont_d  = cont_q;
        ovf_d   = ovf_q;
        vld_d   = 1'b0;
        if (sel_chg) begin
            state_d = IDLE;
            sat_d   = 1'b0;
            cont_d  = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE:  state_d = gate_edge ? COUNT : IDLE;
                COUNT: begin
                    clr     = 1'b0;
                    inc     = sig_edge;
                    sat_d   = sat_q | full;
                    state_d = gate_edge ? LATCH : COUNT;
                end
                LATCH: begin
                    inc     = sig_edge;
                    cont_d  = cnt;
                    ovf_d   = sat_q;
                    vld_d   = 1'b1;
                    sat_d   = 1'b0;
                    state_d = COUNT;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk100KHZ) begin
        if (rst) begin
            state_q <= IDLE;
            sync_q  <= '0;
            gate_q  <= '0;
            sel_q   <= seletor;
            sat_q   <= 1'b0;
            cont_q  <= '0;
            ovf_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[1:0], sinal};
            gate_q  <= {gate_q[0], gate};
            sel_q   <= seletor;
            sat_q   <= sat_d;
            cont_q  <= cont_d;
            ovf_q   <= ovf_d;
            vld_q   <= vld_d;
        end
    end
    assign contagem = cont_q;
    assign overflow = ovf_q;
    assign valido   = vld_q;
    assign medindo  = state_q == COUNT;
endmodule

// File: tb/tb_freq_gate_counter.sv
// tb_freq_gate_counter: table rows, corner sequences and random stimulus vs a window-level model
module tb_freq_gate_counter;
    localparam int NMAX = 65536;
    logic clk = 1'b0;
    logic rst, gate, sinal;
    logic [3:0] seletor;
    logic [15:0] cont4;
    logic [7:0] cont2;
    logic ovf4, ovf2, vld4, vld2, med4, med2;
    always #5 clk = ~clk;
    freq_gate_counter u4 (
        .clk100KHZ(clk), .rst(rst), .gate(gate), .sinal(sinal), .seletor(seletor),
        .contagem(cont4), .overflow(ovf4), .valido(vld4), .medindo(med4)
    );
    freq_gate_counter #(.DIGITS(2)) u2 (
        .clk100KHZ(clk), .rst(rst), .gate(gate), .sinal(sinal), .seletor(seletor),
        .contagem(cont2), .overflow(ovf2), .valido(vld2), .medindo(med2)
    );
    typedef struct {
        bit counting;
        int cnt;
        int pend;
        int latch_at;
        logic [15:0] cont;
        bit ovf;
        bit vld;
        bit med;
    } mdl_t;
    typedef struct {
        int gp;
        int ghi;
        int sp;
        int nwin;
        logic [15:0] e4;
        logic [7:0] e2;
        bit o2;
    } row_t;
    bit gh[NMAX];
    bit sh[NMAX];
    int cyc = 0;
    int rst_at = -1;
    logic [3:0] prev_sel;
    mdl_t m[2];
    int total = 0;
    int bad = 0;
    row_t rows[8];
    function automatic logic [15:0] to_bcd(int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction
    function automatic bit gs(int t);
        return (t > rst_at && t >= 0) ? gh[t] : 1'b0;
    endfunction
    function automatic bit ss(int t);
        return (t > rst_at && t >= 0) ? sh[t] : 1'b0;
    endfunction
    // a window closed by gate act n holds every sinal act in [previous n + 1, n]
    function automatic mdl_t mstep(mdl_t x, int mx, bit sel, bit ga, bit sa, int a);
        mdl_t y = x;
        y.vld = 1'b0;
        if (sel) begin
            y.counting = 1'b0;
            y.cnt = 0;
            y.latch_at = -1;
            y.cont = '0;
            y.ovf = 1'b0;
        end else if (y.latch_at == a) begin
            y.vld = 1'b1;
            y.cont = to_bcd(y.pend > mx ? mx : y.pend);
            y.ovf = y.pend > mx;
            y.cnt = int'(sa);
            y.latch_at = -1;
        end else if (y.counting) begin
            y.cnt += int'(sa);
            if (ga) begin
                y.pend = y.cnt;
                y.latch_at = a + 1;
            end
        end else if (ga) begin
            y.counting = 1'b1;
            y.cnt = 0;
        end
        y.med = y.counting && y.latch_at != a + 1;
        return y;
    endfunction
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask
    task automatic model_step();
        bit sel, ga, sa;
        if (cyc >= NMAX) begin
            $display("FAIL cycle_budget cycle=%0d got=over expected=under_%0d", cyc, NMAX);
            $fatal(1, "cycle budget exhausted");
        end
        gh[cyc] = gate;
        sh[cyc] = sinal;
        if (rst) begin
            rst_at = cyc;
            prev_sel = seletor;
            foreach (m[k]) begin
                m[k] = '{default: 0};
                m[k].latch_at = -1;
            end
        end else begin
            sel = seletor != prev_sel;
            prev_sel = seletor;
            ga = gs(cyc - 1) & ~gs(cyc - 2);
            sa = ss(cyc - 2) & ~ss(cyc - 3);
            m[0] = mstep(m[0], 9999, sel, ga, sa, cyc);
            m[1] = mstep(m[1], 99, sel, ga, sa, cyc);
        end
        cyc++;
    endtask
    task automatic check_all();
        chk("m4_cont", {16'h0, cont4}, {16'h0, m[0].cont});
        chk("m4_ovf", {31'h0, ovf4}, {31'h0, m[0].ovf});
        chk("m4_vld", {31'h0, vld4}, {31'h0, m[0].vld});
        chk("m4_med", {31'h0, med4}, {31'h0, m[0].med});
        chk("m2_cont", {24'h0, cont2}, {16'h0, m[1].cont});
        chk("m2_ovf", {31'h0, ovf2}, {31'h0, m[1].ovf});
        chk("m2_vld", {31'h0, vld2}, {31'h0, m[1].vld});
        chk("m2_med", {31'h0, med2}, {31'h0, m[1].med});
    endtask
    task automatic tick();
        model_step();
        @(negedge clk);
        check_all();
    endtask
    function automatic bit sig_at(int ph, int sp);
        return sp == 0 ? 1'b0 : (ph % sp) < (sp / 2);
    endfunction
    task automatic restart();
        seletor = seletor + 4'd1;
        gate = 1'b0;
        sinal = 1'b0;
        repeat (21) tick();
    endtask
    task automatic run_row(row_t r);
        int ns = 0;
        int first = -1;
        restart();
        for (int ph = 0; ph < r.gp * r.nwin; ph++) begin
            gate = (ph % r.gp) < r.ghi;
            sinal = sig_at(ph, r.sp);
            tick();
            if (vld4) begin
                if (first < 0) first = ph;
                ns++;
                chk("row_cont4", cont4, r.e4);
                chk("row_ovf4", ovf4, 0);
            end
            if (vld2) begin
                chk("row_cont2", cont2, r.e2);
                chk("row_ovf2", ovf2, r.o2);
            end
        end
        chk("row_strobes", ns, r.nwin - 1);
        chk("row_first", first, r.gp + 2);
    endtask
    task automatic coinc(int p, int w);
        int idx = 0;
        restart();
        for (int ph = 0; ph < 450; ph++) begin
            gate = (ph % 100) < 50;
            sinal = (ph == p) || (ph == p + 1);
            tick();
            if (vld4) begin
                chk("coinc_time", ph, 102 + 100 * idx);
                chk("coinc_val", cont4, idx == w ? 1 : 0);
                idx++;
            end
        end
        chk("coinc_n", idx, 4);
    endtask
    task automatic interrupt(bit use_rst);
        int first = -1;
        restart();
        for (int ph = 0; ph < 500; ph++) begin
            gate = (ph % 100) < 50;
            sinal = sig_at(ph, 10);
            if (ph == 150 && use_rst) begin
                chk("int_pre_med", med4, 1);
                chk("int_pre_cont", cont4, 16'h0010);
                rst = 1'b1;
            end
            if (ph == 130 && !use_rst) seletor = seletor + 4'd1;
            tick();
            rst = 1'b0;
            if (ph == (use_rst ? 150 : 130)) begin
                chk("int_cont", cont4, 0);
                chk("int_med", med4, 0);
                chk("int_vld", vld4, 0);
                chk("int_ovf", ovf4, 0);
            end
            if (vld4 && ph > 130 && first < 0) begin
                first = ph;
                chk("int_val", cont4, 16'h0010);
            end
        end
        chk("int_first", first, 302);
    endtask
    task automatic rand_seg();
        int gp, ghi, sp;
        gp = $urandom_range(600, 4);
        ghi = $urandom_range(gp - 1, 1);
        sp = $urandom_range(12, 0);
        for (int ph = 0; ph < gp * 4; ph++) begin
            gate = (ph % gp) < ghi;
            sinal = sp < 2 ? 1'($urandom_range(1, 0)) : sig_at(ph, sp);
            rst = $urandom_range(999, 0) == 0;
            if (!rst && $urandom_range(799, 0) == 0) seletor = seletor + 4'd1;
            tick();
            rst = 1'b0;
        end
    endtask
    initial begin
        rows[0] = '{gp: 100,  ghi: 50,  sp: 10, nwin: 5, e4: 16'h0010, e2: 8'h10, o2: 1'b0};
        rows[1] = '{gp: 1000, ghi: 500, sp: 4,  nwin: 3, e4: 16'h0250, e2: 8'h99, o2: 1'b1};
        rows[2] = '{gp: 1000, ghi: 500, sp: 20, nwin: 3, e4: 16'h0050, e2: 8'h50, o2: 1'b0};
        rows[3] = '{gp: 100,  ghi: 50,  sp: 0,  nwin: 5, e4: 16'h0000, e2: 8'h00, o2: 1'b0};
        rows[4] = '{gp: 60,   ghi: 10,  sp: 3,  nwin: 4, e4: 16'h0020, e2: 8'h20, o2: 1'b0};
        rows[5] = '{gp: 8,    ghi: 4,   sp: 2,  nwin: 6, e4: 16'h0004, e2: 8'h04, o2: 1'b0};
        rows[6] = '{gp: 500,  ghi: 250, sp: 5,  nwin: 3, e4: 16'h0100, e2: 8'h99, o2: 1'b1};
        rows[7] = '{gp: 495,  ghi: 200, sp: 5,  nwin: 3, e4: 16'h0099, e2: 8'h99, o2: 1'b0};
        rst = 1'b1;
        gate = 1'b1;
        sinal = 1'b1;
        seletor = 4'd3;
        repeat (3) tick();
        chk("reset_cont", cont4, 0);
        chk("reset_ovf", ovf4, 0);
        chk("reset_vld", vld4, 0);
        chk("reset_med", med4, 0);
        rst = 1'b0;
        foreach (rows[i]) run_row(rows[i]);
        coinc(99, 0);
        coinc(199, 1);
        coinc(200, 2);
        interrupt(1'b0);
        interrupt(1'b1);
        for (int s = 0; s < 16; s++) rand_seg();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
